// File: rtl/spi_rx_if.sv
// Port bundle for spi_rx: serial link inputs plus the VALID/READY word port and error pulses.
interface spi_rx_if #(
  parameter int DATA_LENGTH = 8
);
  logic                   MCLK;
  logic                   SS_N;
  logic                   MISO;
  logic                   READY;
  logic [DATA_LENGTH-1:0] DATA;
  logic                   VALID;
  logic                   OVERRUN;
  logic                   FRAME_ERR;

  modport slave (
    input  MCLK, SS_N, MISO, READY,
    output DATA, VALID, OVERRUN, FRAME_ERR
  );

  modport master (
    output MCLK, SS_N, MISO, READY,
    input  DATA, VALID, OVERRUN, FRAME_ERR
  );
endinterface

// File: rtl/spi_rx.sv
// SPI mode-0 receiver: samples MISO on MCLK rises while SS_N is low, emits MSB-first words on VALID/READY.
// Optional macro SPI_RX_SYNC_EN adds 2-flop synchronizers on MCLK, SS_N and MISO.
module spi_rx #(
  parameter int DATA_LENGTH = 8
) (
  input  logic     CLK,
  input  logic     RST_N,
  spi_rx_if.slave  bus
);
  localparam int CW = (DATA_LENGTH > 2) ? $clog2(DATA_LENGTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_LENGTH - 1);

  logic mclk, ss_n, miso;

`ifdef SPI_RX_SYNC_EN
  localparam int ARM = 3;
  logic [1:0] mclk_sy, ss_sy, miso_sy;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mclk_sy <= 2'b00;
      ss_sy   <= 2'b11;
      miso_sy <= 2'b00;
    end else begin
      mclk_sy <= {mclk_sy[0], bus.MCLK};
      ss_sy   <= {ss_sy[0],   bus.SS_N};
      miso_sy <= {miso_sy[0], bus.MISO};
    end
  end

  assign mclk = mclk_sy[1];
  assign ss_n = ss_sy[1];
  assign miso = miso_sy[1];
`else
  localparam int ARM = 1;
  assign mclk = bus.MCLK;
  assign ss_n = bus.SS_N;
  assign miso = bus.MISO;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic                   mclk_q;
  logic [ARM-1:0]         arm_q;
  logic [CW-1:0]          cnt_q;
  logic [DATA_LENGTH-1:0] shift_r, data_q, word;
  logic                   valid_q, ovr_q, ferr_q;
  logic                   rise, shift_en, cnt_clr, ferr_set, done;

  // arm_q keeps an MCLK already high at reset release (or still draining the
  // synchronizer) from being mistaken for a rise.
  assign rise = mclk && !mclk_q && !ss_n && arm_q[ARM-1];
  assign word = {shift_r[DATA_LENGTH-2:0], miso};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!ss_n) state_d = SHIFT;
      SHIFT:   if (ss_n)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_en = rise;
    cnt_clr  = ss_n;
    ferr_set = (state_q == SHIFT) && ss_n && (cnt_q != '0);
    done     = rise && (cnt_q == LAST);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mclk_q  <= 1'b0;
      arm_q   <= '0;
      cnt_q   <= '0;
      shift_r <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      mclk_q <= mclk;
      arm_q  <= (arm_q << 1) | ARM'(1);
      ovr_q  <= 1'b0;
      ferr_q <= ferr_set;

      if (cnt_clr)       cnt_q <= '0;
      else if (shift_en) cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

      if (shift_en) shift_r <= word;

      // A completing word either lands in a free/draining slot or is dropped.
      if (done) begin
        if (!valid_q || bus.READY) begin
          data_q  <= word;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && bus.READY) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.DATA      = data_q;
  assign bus.VALID     = valid_q;
  assign bus.OVERRUN   = ovr_q;
  assign bus.FRAME_ERR = ferr_q;
endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx: scoreboard of expected words checked at each VALID&&READY handshake.
module tb_spi_rx;
`ifdef SPI_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic CLK = 1'b0;
  logic RST_N;
  int   n_chk = 0, n_pass = 0;
  int   ovr_cnt = 0, ferr_cnt = 0;
  int   ovr_base, ferr_base;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  spi_rx_if #(.DATA_LENGTH(8)) bus ();
  spi_rx #(.DATA_LENGTH(8)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Values seen mid-cycle are exactly those the next rising edge acts on.
  always begin
    @(negedge CLK);
    #1;
    if (bus.OVERRUN)   ovr_cnt++;
    if (bus.FRAME_ERR) ferr_cnt++;
    if (bus.VALID && bus.READY) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        chk("sb_data", bus.DATA, exp_w);
      end
    end
  end

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge CLK); bus.MCLK = 1'b0; bus.MISO = w[i];
      @(negedge CLK); bus.MCLK = 1'b1;
    end
  endtask

  task automatic start_frame();
    @(negedge CLK); bus.SS_N = 1'b0;
  endtask

  task automatic end_frame();
    @(negedge CLK); bus.MCLK = 1'b0;
    @(negedge CLK); bus.SS_N = 1'b1;
    repeat (LAT + 3) @(negedge CLK);
  endtask

  initial begin
    RST_N = 1'b0; bus.SS_N = 1'b1; bus.MCLK = 1'b0; bus.MISO = 1'b0; bus.READY = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_data", bus.DATA, 8'h00);
    chk("rst_valid", bus.VALID, 0);
    chk("rst_ovr", bus.OVERRUN, 0);
    chk("rst_ferr", bus.FRAME_ERR, 0);

    // single word, READY high: VALID for exactly one cycle on the 8th rise
    ovr_base = ovr_cnt; ferr_base = ferr_cnt;
    @(negedge CLK); bus.READY = 1'b1;
    start_frame();
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 8);
    chk("a5_pre_valid", bus.VALID, 0);
    repeat (LAT) @(posedge CLK);
    @(posedge CLK); #1;
    chk("a5_valid", bus.VALID, 1);
    chk("a5_data", bus.DATA, 8'hA5);
    @(posedge CLK); #1;
    chk("a5_valid_drop", bus.VALID, 0);
    end_frame();
    chk("a5_no_ovr", 32'(ovr_cnt - ovr_base), 0);
    chk("a5_no_ferr", 32'(ferr_cnt - ferr_base), 0);

    // two words, READY low: second word dropped with OVERRUN
    ovr_base = ovr_cnt;
    @(negedge CLK); bus.READY = 1'b0;
    start_frame();
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 8);
    send_bits(8'hC3, 8);
    repeat (LAT) @(posedge CLK);
    @(posedge CLK); #1;
    chk("ovr_pulse", bus.OVERRUN, 1);
    chk("ovr_data_kept", bus.DATA, 8'h3C);
    chk("ovr_valid", bus.VALID, 1);
    end_frame();
    chk("ovr_once", 32'(ovr_cnt - ovr_base), 1);
    bus.READY = 1'b1;
    repeat (2) @(negedge CLK);
    chk("ovr_drain_valid", bus.VALID, 0);
    bus.READY = 1'b0;

    // two words, READY rises just before the second completion: no overrun
    ovr_base = ovr_cnt;
    start_frame();
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_bits(8'h3C, 8);
    send_bits(8'hC3, 7);
    @(negedge CLK); bus.MCLK = 1'b0; bus.MISO = 1'b1;
    @(negedge CLK); bus.MCLK = 1'b1;
    repeat (LAT) @(negedge CLK);
    chk("rdy_old_valid", bus.VALID, 1);
    chk("rdy_old_data", bus.DATA, 8'h3C);
    bus.READY = 1'b1;
    @(posedge CLK); #1;
    chk("rdy_new_valid", bus.VALID, 1);
    chk("rdy_new_data", bus.DATA, 8'hC3);
    chk("rdy_no_ovr_now", bus.OVERRUN, 0);
    end_frame();
    chk("rdy_no_ovr", 32'(ovr_cnt - ovr_base), 0);

    // SS_N raised mid-word: one FRAME_ERR, partial bits discarded
    ferr_base = ferr_cnt;
    start_frame();
    send_bits(8'hFF, 5);
    @(negedge CLK); bus.MCLK = 1'b0;
    @(negedge CLK); bus.SS_N = 1'b1;
    repeat (LAT) @(posedge CLK);
    @(posedge CLK); #1;
    chk("ferr_pulse", bus.FRAME_ERR, 1);
    @(posedge CLK); #1;
    chk("ferr_width", bus.FRAME_ERR, 0);
    repeat (LAT + 3) @(negedge CLK);
    chk("ferr_once", 32'(ferr_cnt - ferr_base), 1);
    chk("ferr_valid", bus.VALID, 0);
    start_frame();
    exp_q.push_back(8'h81);
    send_bits(8'h81, 8);
    end_frame();
    chk("after_ferr_data", bus.DATA, 8'h81);

    // reset mid-frame, released with SS_N low and MCLK high
    ferr_base = ferr_cnt;
    start_frame();
    send_bits(8'hFF, 3);
    @(negedge CLK); RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("mid_rst_data", bus.DATA, 8'h00);
    chk("mid_rst_valid", bus.VALID, 0);
    RST_N = 1'b1;
    repeat (LAT + 3) @(negedge CLK);
    chk("rel_no_valid", bus.VALID, 0);
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 8);
    repeat (LAT) @(posedge CLK);
    @(posedge CLK); #1;
    chk("rel_valid", bus.VALID, 1);
    chk("rel_data", bus.DATA, 8'h5A);
    end_frame();
    chk("rel_data_hold", bus.DATA, 8'h5A);
    chk("rel_no_ferr", 32'(ferr_cnt - ferr_base), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
